bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL take parameter NREQ, default 4, the number of bus requesters (TLB walker, I-cache, D-cache, D-TLB walker); legal range 2..8.
REQ-002 SHALL take parameter TIMEOUT, default 8, the maximum cycles a granted requester may take to assert busy.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, NREQ, per-requester bus request (abtr_reqcyc); level-held until served or withdrawn.
REQ-006 SHALL have port busy, input, NREQ, per-requester "bus in use" indication (bus_busy).
REQ-007 SHALL have port grant, output, NREQ, one-hot-or-zero grant (abtr_grant), registered.
REQ-008 SHALL have port owner, output, clog2(NREQ), index of the current grantee, registered.
REQ-009 SHALL have port owner_valid, output, 1, high exactly when grant is non-zero.
REQ-010 SHALL have port timeout_pulse, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-011 SHALL implement states IDLE, WAIT_BUSY, OWNED, TURNAROUND; grant non-zero only in WAIT_BUSY and OWNED.
REQ-012 IDLE: if req non-zero at an edge, SHALL select the first set bit searching upward from rr_ptr with wrap past NREQ-1 to 0, set grant[sel]=1, owner=sel, clear wait counter, enter WAIT_BUSY at that edge.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled high in IDLE at edge k -> grant high after edge k.
REQ-014 WAIT_BUSY: busy[owner]=1 SHALL enter OWNED, grant held.
REQ-015 WAIT_BUSY: busy[owner]=0 and req[owner]=0 SHALL enter TURNAROUND (withdrawn request), no timeout_pulse.
REQ-016 WAIT_BUSY: busy[owner]=0, req[owner]=1, counter==TIMEOUT-1 SHALL enter TURNAROUND and assert timeout_pulse for one cycle; otherwise counter increments.
REQ-017 Withdrawal (REQ-015) SHALL take priority over timeout (REQ-016) when both hold on the same edge.
REQ-018 OWNED: grant held while busy[owner]=1; busy[owner]=0 SHALL enter TURNAROUND; req[owner] is ignored in OWNED.
REQ-019 TURNAROUND SHALL last exactly one cycle with grant=0, owner_valid=0, set rr_ptr=(owner+1) mod NREQ, then enter IDLE.
REQ-020 Minimum gap between two grants SHALL be two idle cycles (TURNAROUND then IDLE).
REQ-021 busy and req from non-owners SHALL be ignored while a grant is active; pending requests keep waiting.
REQ-022 grant SHALL never have more than one bit set.
REQ-023 owner SHALL retain its last value when owner_valid=0.
REQ-024 The wait counter SHALL be clog2(TIMEOUT)+1 bits and SHALL never wrap.

Reset
REQ-025 On reset SHALL set state=IDLE, rr_ptr=0, grant=0, owner=0, owner_valid=0, timeout_pulse=0, counter=0.
REQ-026 Reset asserted in WAIT_BUSY or OWNED SHALL drop grant after that edge with no TURNAROUND cycle and no timeout_pulse.
REQ-027 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-028 Single request: NREQ=4, req=0010 at edge 1 -> grant=0010, owner=1 after edge 1; busy[1]=1 for 3 cycles then 0 -> grant=0 one cycle after busy falls, rr_ptr=2.
REQ-029 Round-robin: req=1111 held, each grantee asserts then drops busy -> grant order 0001, 0010, 0100, 1000, 0001 with two grant-free cycles between grants.
REQ-030 Wrap: rr_ptr=3, req=0101 -> grant=0001 (wraps past 3 to 0), then grant=0100 on next arbitration.
REQ-031 Timeout: TIMEOUT=8, req=0100 held, busy never asserted -> grant=0 and timeout_pulse=1 exactly 8 cycles after grant rose, next grant goes to another requester if any is pending.
REQ-032 Withdraw vs timeout collision: req[owner] dropped on the edge counter==TIMEOUT-1 -> TURNAROUND with timeout_pulse=0.
REQ-033 Reset mid-ownership: reset asserted while grant=1000 and busy[3]=1 -> grant=0, owner_valid=0 after that edge; next req=1001 -> grant=0001.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake interface.
//   req, busy     : per-requester request and "bus in use" (driven by requesters)
//   grant         : one-hot-or-zero grant (driven by arbiter)
//   owner         : index of the current grantee
//   owner_valid   : high while grant is non-zero
//   timeout_pulse : one-cycle pulse when a grant is revoked by timeout
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         busy;
    logic [NREQ-1:0]         grant;
    logic [$clog2(NREQ)-1:0] owner;
    logic                    owner_valid;
    logic                    timeout_pulse;

    modport master (
        output req, busy,
        input  grant, owner, owner_valid, timeout_pulse
    );

    modport slave (
        input  req, busy,
        output grant, owner, owner_valid, timeout_pulse
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with busy-acknowledge timeout.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : bus_arbiter_if.slave (req/busy in; grant/owner/owner_valid/
//           timeout_pulse out)
// A granted requester must raise busy within TIMEOUT cycles or lose the
// grant. Every grant release goes through a one-cycle TURNAROUND, so back-to-
// back grants are always separated by two grant-free cycles.
module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        OWNED,
        TURNAROUND
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            tpulse_q, tpulse_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [OW-1:0]   sel;
    logic            sel_found;

    function automatic logic [OW-1:0] wrap_idx(input int v);
        return OW'(v % NREQ);
    endfunction

    // First set request at or above rr_ptr, wrapping past NREQ-1 to 0.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && bus.req[wrap_idx(int'(rr_ptr_q) + i)]) begin
                sel       = wrap_idx(int'(rr_ptr_q) + i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        tpulse_d = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    cnt_d        = '0;
                    state_d      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Withdrawal is checked before timeout so a request dropped on
                // the final wait cycle never reports a timeout.
                if (bus.busy[owner_q]) begin
                    state_d = OWNED;
                end else if (!bus.req[owner_q]) begin
                    grant_d = '0;
                    state_d = TURNAROUND;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    grant_d  = '0;
                    tpulse_d = 1'b1;
                    state_d  = TURNAROUND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWNED: begin
                if (!bus.busy[owner_q]) begin
                    grant_d = '0;
                    state_d = TURNAROUND;
                end
            end
            TURNAROUND: begin
                rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
                state_d  = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            tpulse_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            tpulse_q <= tpulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.owner         = owner_q;
    assign bus.owner_valid   = |grant_q;
    assign bus.timeout_pulse = tpulse_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NREQ=4, TIMEOUT=8). Each stimulus step
// pushes the hand-computed post-edge outputs tagged with the cycle they are
// due; the monitor pops and compares on the falling edge of that cycle.
module tb_bus_arbiter;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [1:0] own;
        logic       ov;
        logic       tp;
        string      name;
    } exp_t;

    exp_t q[$];

    bus_arbiter_if #(.NREQ(4)) bif ();

    bus_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bif.grant) || (bif.owner_valid != (|bif.grant))) begin
            errors++;
            $display("FAIL onehot_ov cyc=%0d grant=%b owner_valid=%b", cyc, bif.grant, bif.owner_valid);
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s missed cyc=%0d due=%0d", e.name, cyc, e.cyc);
            end else if (bif.grant !== e.g || bif.owner !== e.own ||
                         bif.owner_valid !== e.ov || bif.timeout_pulse !== e.tp) begin
                errors++;
                $display("FAIL %s cyc=%0d got g=%b own=%0d ov=%b tp=%b want g=%b own=%0d ov=%b tp=%b",
                         e.name, cyc, bif.grant, bif.owner, bif.owner_valid, bif.timeout_pulse,
                         e.g, e.own, e.ov, e.tp);
            end
        end
    end

    // Drive inputs for the next edge and queue what must appear after it.
    task automatic tick(input logic rst, input logic [3:0] r, input logic [3:0] b,
                        input logic [3:0] g, input logic [1:0] o, input logic tp,
                        input string nm);
        exp_t e;
        reset    = rst;
        bif.req  = r;
        bif.busy = b;
        e.cyc  = cyc + 1;
        e.g    = g;
        e.own  = o;
        e.ov   = |g;
        e.tp   = tp;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] oh;
    logic [1:0] oi;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bif.req  = '0;
        bif.busy = '0;

        // Reset state, even with a request pending
        tick(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset0");
        tick(1, 4'b0010, 4'b0000, 4'b0000, 2'd0, 0, "reset1");

        // Single request, ownership for 3 busy cycles
        tick(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "single_grant");
        tick(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0, "single_own1");
        tick(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0, "single_own2");
        tick(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0, "single_own3");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "single_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "single_idle");
        // rr_ptr now 2: 1011 must pick 3
        tick(0, 4'b1011, 4'b0000, 4'b1000, 2'd3, 0, "rr_after_single");
        tick(0, 4'b0000, 4'b1000, 4'b1000, 2'd3, 0, "own3");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0, "own3_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0, "own3_idle");

        // Round robin with all requesting
        for (int k = 0; k < 5; k++) begin
            oi = 2'(k % 4);
            oh = 4'b0001 << oi;
            tick(0, 4'b1111, 4'b0000, oh,      oi, 0, "rr_grant");
            tick(0, 4'b1111, oh,      oh,      oi, 0, "rr_owned");
            tick(0, 4'b1111, 4'b0000, 4'b0000, oi, 0, "rr_turn");
            tick(0, 4'b1111, 4'b0000, 4'b0000, oi, 0, "rr_idle");
        end

        // Withdraw in WAIT_BUSY (sets rr_ptr=3, no timeout pulse)
        tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "wd_grant");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "wd_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "wd_idle");

        // Wrap from rr_ptr=3; non-owner busy/req ignored
        tick(0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0, "wrap_grant");
        tick(0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 0, "wrap_owned");
        tick(0, 4'b0101, 4'b0100, 4'b0000, 2'd0, 0, "wrap_turn");
        tick(0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "wrap_idle");
        tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "wrap_next");
        tick(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0, "wrap_next_own");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "wrap_next_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "wrap_next_idle");

        // Timeout: rr_ptr=3, requester 1 becomes pending during the wait
        tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "to_grant");
        for (int k = 0; k < 7; k++)
            tick(0, 4'b0110, 4'b0000, 4'b0100, 2'd2, 0, "to_wait");
        tick(0, 4'b0110, 4'b0000, 4'b0000, 2'd2, 1, "to_pulse");
        tick(0, 4'b0110, 4'b0000, 4'b0000, 2'd2, 0, "to_idle");
        tick(0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 0, "to_next");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "to_next_wd");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "to_next_idle");

        // Withdraw on the final wait cycle: no pulse
        tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "coll_grant");
        for (int k = 0; k < 7; k++)
            tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "coll_wait");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "coll_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "coll_idle");

        // Reset mid-ownership
        tick(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 0, "rst_grant");
        tick(0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 0, "rst_owned");
        tick(1, 4'b1000, 4'b1000, 4'b0000, 2'd0, 0, "rst_drop");
        tick(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 0, "rst_first");
        tick(0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 0, "rst_first_own");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst_first_turn");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rst_first_idle");

        // Reset while waiting at the timeout edge: no pulse, no turnaround
        tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "rstw_grant");
        for (int k = 0; k < 7; k++)
            tick(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "rstw_wait");
        tick(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, "rstw_drop");
        tick(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "rstw_after");

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
